// File: rtl/control_unit_mc.sv
// control_unit_mc
//   Multi-cycle decode/control unit for the pipelined ARM/camera core.
//   D-stage steering signals are decoded combinationally from funct/opcode.
//   E-stage controls live in an internal D->E register. A small FSM sequences
//   latency-stalled MULT/AVERAGE (MULTI) and store-plus-one bursts (BURST),
//   raising stall_out while the block owns the E stage.
//
//   Optional feature macro: CU_ILLEGAL_TRAP_EN
//     defined   : undefined cmd with valid_d sets sticky illegal_o and issues
//                 as a full bubble.
//     undefined : illegal_o tied to 0, undefined cmds decode as FNOP.
//
// Ports
//   clk, rst_n                : clock, synchronous active-low reset
//   valid_d, stall_in         : D holds an instruction / hazard-unit stall
//   flush_in                  : kill E-stage instruction
//   funct, opcode, burst_len  : instruction fields, store-plus-one repeat count
//   RegSrcD, ImmSrcD,
//   BranchD, PCSrcD           : D-stage steering (combinational)
//   ALUSrcE, ALUControlE,
//   MemToRegE, RegWriteE,
//   MemWriteE, PlusOneE,
//   BranchE                   : E-stage controls (registered)
//   stall_out                 : block busy, D must hold
//   burst_idx                 : current burst beat index
//   illegal_o                 : sticky undefined-cmd flag
module control_unit_mc #(
   parameter int ALUCTL_W  = 4,
   parameter int MULT_LAT  = 3,
   parameter int AV_LAT    = 2,
   parameter int BURST_MAX = 16,
   parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_d,
   input  logic                stall_in,
   input  logic                flush_in,
   input  logic [5:0]          funct,
   input  logic [1:0]          opcode,
   input  logic [CNT_W-1:0]    burst_len,
   output logic [1:0]          RegSrcD,
   output logic [1:0]          ImmSrcD,
   output logic                BranchD,
   output logic                PCSrcD,
   output logic                ALUSrcE,
   output logic [ALUCTL_W-1:0] ALUControlE,
   output logic                MemToRegE,
   output logic                RegWriteE,
   output logic                MemWriteE,
   output logic                PlusOneE,
   output logic                BranchE,
   output logic                stall_out,
   output logic [CNT_W-1:0]    burst_idx,
   output logic                illegal_o
);

   localparam logic [3:0] FNOP = 4'd0, FADD = 4'd1, FSUB = 4'd2, FMULT = 4'd3,
                          FLOAD = 4'd4, FSTR = 4'd5, FAVERAGE = 4'd6,
                          FSTR_ONE = 4'd7, FPIC = 4'd8, FB = 4'd9;

   localparam logic [CNT_W-1:0] BMAX   = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] M_INIT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] A_INIT = CNT_W'(AV_LAT - 1);

   typedef struct packed {
      logic                alusrc;
      logic [ALUCTL_W-1:0] alu;
      logic                memtoreg;
      logic                regwrite;
      logic                memwrite;
      logic                plusone;
      logic                branch;
   } ectl_t;

   typedef enum logic [1:0] {IDLE, MULTI, BURST} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   ectl_t            e_q;
   ectl_t            dec_e;
   logic [3:0]       cmd;
   logic             undef;
   logic [CNT_W-1:0] eff_len;
   logic             unused;

   assign cmd    = funct[4:1];
   assign undef  = (cmd > FB);
   assign unused = funct[5];

   // D-stage steering
   assign RegSrcD = {(opcode == 2'b01) & ~funct[0], (opcode == 2'b10)};
   assign ImmSrcD = {(cmd == FB), (cmd == FSTR) | (cmd == FLOAD)};
   assign BranchD = (opcode == 2'b10);
   assign PCSrcD  = (opcode == 2'b10);

   // Zero-length bursts still issue one beat; long ones clamp to BURST_MAX.
   assign eff_len = (burst_len == '0)  ? ONE :
                    (burst_len > BMAX) ? BMAX : burst_len;

   always_comb begin
      dec_e        = '0;
      dec_e.alusrc = opcode[0];
      dec_e.branch = (opcode == 2'b10);
      case (cmd)
         FADD:     begin dec_e.alu = ALUCTL_W'(3'd1); dec_e.regwrite = 1'b1; end
         FSUB:     begin dec_e.alu = ALUCTL_W'(3'd2); dec_e.regwrite = 1'b1; end
         FMULT:    begin dec_e.alu = ALUCTL_W'(3'd3); dec_e.regwrite = 1'b1; end
         FLOAD:    begin dec_e.alu = ALUCTL_W'(3'd4); dec_e.regwrite = 1'b1;
                         dec_e.memtoreg = 1'b1; end
         FSTR:     begin dec_e.alu = ALUCTL_W'(3'd4); dec_e.memwrite = 1'b1; end
         FAVERAGE: begin dec_e.alu = ALUCTL_W'(3'd5); dec_e.regwrite = 1'b1; end
         FSTR_ONE: begin dec_e.alu = ALUCTL_W'(3'd4); dec_e.memwrite = 1'b1;
                         dec_e.plusone = 1'b1; end
         FB:       dec_e.regwrite = 1'b1;
         default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            // trapped undefined cmds become a true bubble
            if (undef) begin
               dec_e.alusrc = 1'b0;
               dec_e.branch = 1'b0;
            end
`endif
         end
      endcase
   end

`ifdef CU_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (!rst_n)
         illegal_q <= 1'b0;
      else if (!flush_in && !stall_in && state == IDLE && valid_d && undef)
         illegal_q <= 1'b1;
   end
   assign illegal_o = illegal_q;
`else
   assign illegal_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         burst_idx <= '0;
         stall_out <= 1'b0;
         e_q       <= '0;
      end else if (flush_in) begin
         state     <= IDLE;
         cnt       <= '0;
         burst_idx <= '0;
         stall_out <= 1'b0;
         e_q       <= '0;
      end else if (!stall_in) begin
         case (state)
            IDLE: begin
               burst_idx <= '0;
               stall_out <= 1'b0;
               e_q       <= valid_d ? dec_e : '0;
               if (valid_d) begin
                  if (cmd == FMULT && MULT_LAT > 1) begin
                     state     <= MULTI;
                     cnt       <= M_INIT;
                     stall_out <= 1'b1;
                  end else if (cmd == FAVERAGE && AV_LAT > 1) begin
                     state     <= MULTI;
                     cnt       <= A_INIT;
                     stall_out <= 1'b1;
                  end else if (cmd == FSTR_ONE && eff_len > ONE) begin
                     state     <= BURST;
                     cnt       <= eff_len - ONE;
                     stall_out <= 1'b1;
                  end
               end
            end
            MULTI: begin
               cnt <= cnt - ONE;
               if (cnt == ONE) begin
                  state     <= IDLE;
                  stall_out <= 1'b0;
               end
            end
            BURST: begin
               // E register holds the store-plus-one: each cycle is a new beat
               cnt       <= cnt - ONE;
               burst_idx <= burst_idx + ONE;
               if (cnt == ONE) begin
                  state     <= IDLE;
                  stall_out <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               stall_out <= 1'b0;
            end
         endcase
      end
   end

   assign ALUSrcE     = e_q.alusrc;
   assign ALUControlE = e_q.alu;
   assign MemToRegE   = e_q.memtoreg;
   assign RegWriteE   = e_q.regwrite;
   assign MemWriteE   = e_q.memwrite;
   assign PlusOneE    = e_q.plusone;
   assign BranchE     = e_q.branch;

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc: directed literal checks followed by
// randomized stimulus compared every cycle against an occupancy-based model.
module tb_control_unit_mc;

`ifdef CU_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int MULT_LAT = 3, AV_LAT = 2, BURST_MAX = 16;

   logic       clk = 1'b0;
   logic       rst_n, valid_d, stall_in, flush_in;
   logic [5:0] funct;
   logic [1:0] opcode;
   logic [4:0] burst_len;
   logic [1:0] RegSrcD, ImmSrcD;
   logic       BranchD, PCSrcD, ALUSrcE;
   logic [3:0] ALUControlE;
   logic       MemToRegE, RegWriteE, MemWriteE, PlusOneE, BranchE;
   logic       stall_out, illegal_o;
   logic [4:0] burst_idx;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   control_unit_mc #(.ALUCTL_W(4), .MULT_LAT(MULT_LAT), .AV_LAT(AV_LAT),
                     .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .stall_in(stall_in),
      .flush_in(flush_in), .funct(funct), .opcode(opcode), .burst_len(burst_len),
      .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .BranchD(BranchD), .PCSrcD(PCSrcD),
      .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemToRegE(MemToRegE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PlusOneE(PlusOneE),
      .BranchE(BranchE), .stall_out(stall_out), .burst_idx(burst_idx),
      .illegal_o(illegal_o));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic       alusrc;
      logic [3:0] alu;
      logic       mtr, rw, mw, po, br;
   } me_t;

   function automatic me_t mdec(input logic [5:0] f, input logic [1:0] op);
      me_t e;
      e = '0;
      e.alusrc = op[0];
      e.br = (op == 2'b10);
      case (f[4:1])
         4'd1: begin e.alu = 4'd1; e.rw = 1'b1; end
         4'd2: begin e.alu = 4'd2; e.rw = 1'b1; end
         4'd3: begin e.alu = 4'd3; e.rw = 1'b1; end
         4'd4: begin e.alu = 4'd4; e.rw = 1'b1; e.mtr = 1'b1; end
         4'd5: begin e.alu = 4'd4; e.mw = 1'b1; end
         4'd6: begin e.alu = 4'd5; e.rw = 1'b1; end
         4'd7: begin e.alu = 4'd4; e.mw = 1'b1; e.po = 1'b1; end
         4'd9: e.rw = 1'b1;
         4'd0, 4'd8: ;
         default: if (TRAP) begin e.alusrc = 1'b0; e.br = 1'b0; end
      endcase
      return e;
   endfunction

   // number of cycles the instruction occupies the E stage
   function automatic int occ(input logic [5:0] f, input logic [4:0] len);
      case (f[4:1])
         4'd3: return MULT_LAT;
         4'd6: return AV_LAT;
         4'd7: return (len == 0) ? 1 : (len > BURST_MAX) ? BURST_MAX : int'(len);
         default: return 1;
      endcase
   endfunction

   me_t m_e = '0;
   int  m_hold = 0, m_idx = 0;
   bit  m_ill = 1'b0, m_burst = 1'b0, started = 1'b0;

   always @(posedge clk) begin
      started <= 1'b1;
      if (!rst_n) begin
         m_e <= '0; m_hold <= 0; m_idx <= 0; m_ill <= 1'b0; m_burst <= 1'b0;
      end else if (flush_in) begin
         m_e <= '0; m_hold <= 0; m_idx <= 0;
      end else if (stall_in) begin
         m_hold <= m_hold;
      end else if (m_hold > 0) begin
         m_hold <= m_hold - 1;
         if (m_burst) m_idx <= m_idx + 1;
      end else begin
         m_idx <= 0;
         if (valid_d) begin
            m_e     <= mdec(funct, opcode);
            m_hold  <= occ(funct, burst_len) - 1;
            m_burst <= (funct[4:1] == 4'd7);
            if (TRAP && funct[4:1] > 4'd9) m_ill <= 1'b1;
         end else begin
            m_e <= '0; m_hold <= 0;
         end
      end
   end

   // compare process: every negedge once the model has seen a clock edge
   always @(negedge clk) begin
      if (started) begin
         chk("ALUControlE", ALUControlE, m_e.alu);
         chk("ALUSrcE",     ALUSrcE,     m_e.alusrc);
         chk("MemToRegE",   MemToRegE,   m_e.mtr);
         chk("RegWriteE",   RegWriteE,   m_e.rw);
         chk("MemWriteE",   MemWriteE,   m_e.mw);
         chk("PlusOneE",    PlusOneE,    m_e.po);
         chk("BranchE",     BranchE,     m_e.br);
         chk("stall_out",   stall_out,   m_hold > 0);
         chk("burst_idx",   burst_idx,   m_idx);
         chk("illegal_o",   illegal_o,   m_ill);
         chk("RegSrcD", RegSrcD, {(opcode == 2'b01) && !funct[0], opcode == 2'b10});
         chk("ImmSrcD", ImmSrcD, {funct[4:1] == 4'd9,
                                  (funct[4:1] == 4'd4) || (funct[4:1] == 4'd5)});
         chk("BranchD", BranchD, opcode == 2'b10);
         chk("PCSrcD",  PCSrcD,  opcode == 2'b10);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [5:0] fn(input logic [3:0] c);
      return {1'b0, c, 1'b0};
   endfunction

   task automatic issue(input logic [3:0] c, input logic [1:0] op, input logic [4:0] len);
      valid_d = 1'b1; funct = fn(c); opcode = op; burst_len = len;
      cyc();
      valid_d = 1'b0;
   endtask

   initial begin
      int beats;
      rst_n = 1'b0; valid_d = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
      funct = '0; opcode = '0; burst_len = '0;
      cyc(); cyc();
      chk("rst stall_out", stall_out, 0);
      chk("rst ALUControlE", ALUControlE, 0);
      chk("rst burst_idx", burst_idx, 0);
      chk("rst illegal_o", illegal_o, 0);
      rst_n = 1'b1;
      cyc();

      // FADD
      issue(4'd1, 2'b00, 0);
      chk("add alu", ALUControlE, 1);
      chk("add rw", RegWriteE, 1);
      chk("add mw", MemWriteE, 0);
      chk("add alusrc", ALUSrcE, 0);
      chk("add stall", stall_out, 0);

      // FMULT: E holds 3 cycles, stall high for the first two
      issue(4'd3, 2'b00, 0);
      chk("mul c1 alu", ALUControlE, 3); chk("mul c1 stall", stall_out, 1);
      cyc();
      chk("mul c2 alu", ALUControlE, 3); chk("mul c2 stall", stall_out, 1);
      cyc();
      chk("mul c3 alu", ALUControlE, 3); chk("mul c3 stall", stall_out, 0);
      cyc();
      chk("mul after alu", ALUControlE, 0);

      // burst of 4
      issue(4'd7, 2'b01, 5'd4);
      for (int i = 0; i < 4; i++) begin
         chk("b4 po", PlusOneE, 1);
         chk("b4 mw", MemWriteE, 1);
         chk("b4 idx", burst_idx, i);
         chk("b4 stall", stall_out, i < 3);
         cyc();
      end
      chk("b4 end po", PlusOneE, 0);

      // burst_len 0 -> one beat
      issue(4'd7, 2'b01, 5'd0);
      chk("b0 po", PlusOneE, 1); chk("b0 stall", stall_out, 0); chk("b0 idx", burst_idx, 0);
      cyc();
      chk("b0 end po", PlusOneE, 0);

      // burst_len 31 -> clamp to 16 beats
      issue(4'd7, 2'b01, 5'd31);
      beats = 0;
      for (int i = 0; i < 40; i++) begin
         if (PlusOneE === 1'b1) beats++;
         cyc();
      end
      chk("b31 beats", beats, 16);

      // stall mid-burst at idx 1
      issue(4'd7, 2'b01, 5'd4);
      cyc();
      chk("bs idx1", burst_idx, 1);
      stall_in = 1'b1;
      cyc(); chk("bs hold1", burst_idx, 1);
      cyc(); chk("bs hold2", burst_idx, 1); chk("bs hold stall", stall_out, 1);
      stall_in = 1'b0;
      cyc(); chk("bs idx2", burst_idx, 2);
      cyc(); chk("bs idx3", burst_idx, 3); chk("bs last stall", stall_out, 0);
      chk("bs last po", PlusOneE, 1);
      cyc(); chk("bs end po", PlusOneE, 0);

      // flush together with stall at idx 2
      issue(4'd7, 2'b01, 5'd4);
      cyc(); cyc();
      chk("fl idx2", burst_idx, 2);
      flush_in = 1'b1; stall_in = 1'b1;
      cyc();
      chk("fl po", PlusOneE, 0); chk("fl mw", MemWriteE, 0);
      chk("fl stall", stall_out, 0); chk("fl idx", burst_idx, 0);
      flush_in = 1'b0; stall_in = 1'b0;
      cyc();

      // undefined cmd 1111
      issue(4'd15, 2'b00, 0);
      chk("undef alu", ALUControlE, 0);
      chk("undef rw", RegWriteE, 0);
      chk("undef ill", illegal_o, TRAP);
      cyc(); cyc();
      chk("undef ill sticky", illegal_o, TRAP);
      rst_n = 1'b0;
      cyc();
      chk("undef ill rst", illegal_o, 0);
      rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         valid_d   = ($urandom_range(0, 9) < 7);
         stall_in  = ($urandom_range(0, 9) == 0);
         flush_in  = ($urandom_range(0, 19) == 0);
         funct     = 6'($urandom);
         opcode    = 2'($urandom_range(0, 3));
         burst_len = 5'($urandom);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Parametrised, multi-cycle successor to the single-cycle decode control unit of the pipelined ARM/camera core. It decodes `funct`/`opcode` in D and drives the D-stage steering signals combinationally. It registers all E-stage control into an internal D→E control register. It sequences two multi-cycle behaviours through an FSM: a latency-stalled MULT/AVERAGE, and a burst store-plus-one (pixel streaming). It raises `stall_out` to the hazard unit while it owns the E stage.

## Interface
Parameters:
- `ALUCTL_W`, 4: width of `ALUControlE`; codes zero-extended.
- `MULT_LAT`, 3: E-stage cycles a MULT occupies (≥1).
- `AV_LAT`, 2: E-stage cycles an AVERAGE occupies (≥1).
- `BURST_MAX`, 16: maximum burst length for store-plus-one.
- `CNT_W`, $clog2(BURST_MAX+1): width of counters and `burst_len`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `valid_d` in 1: D stage holds a real instruction.
- `stall_in` in 1: pipeline stall from the hazard unit.
- `flush_in` in 1: kill the E-stage instruction (branch taken).
- `funct` in 6: instruction funct; cmd = funct[4:1].
- `opcode` in 2: 00 data, 01 memory, 10 branch.
- `burst_len` in CNT_W: repeat count for FSTR_ONE.
- `RegSrcD` out 2: [0] = branch; [1] = memory & ~funct[0].
- `ImmSrcD` out 2: [0] = FSTR|FLOAD; [1] = FB.
- `BranchD`, `PCSrcD` out 1: opcode==10.
- `ALUSrcE` out 1: registered opcode[0].
- `ALUControlE` out ALUCTL_W: registered ALU op.
- `MemToRegE`, `RegWriteE`, `MemWriteE`, `PlusOneE`, `BranchE` out 1: registered controls.
- `stall_out` out 1: block busy; D must hold.
- `burst_idx` out CNT_W: index of the current burst beat.
- `illegal_o` out 1: sticky undefined-cmd flag (see Configuration).

## Operation
- cmd codes: FNOP 0000, FADD 0001, FSUB 0010, FMULT 0011, FLOAD 0100, FSTR 0101, FAVERAGE 0110, FSTR_ONE 0111, FPIC 1000, FB 1001. All other codes are undefined.
- ALU codes: NOP 0, ADD 1, SUB 2, MULT 3, BUFFER 4, AV 5. LOAD, STR and STR_ONE map to BUFFER. FPIC and FB map to NOP. Undefined cmds map to NOP; no high-Z output is ever driven.
- `RegWriteE` = ~(FSTR|FSTR_ONE|FPIC|FNOP|undefined).
- `MemWriteE` = FSTR|FSTR_ONE.
- `MemToRegE` = FLOAD.
- `PlusOneE` = FSTR_ONE.
- FSM states: IDLE, MULTI, BURST.
- IDLE: when `valid_d` & ~`stall_in`, load the E register from decode. `valid_d`=0 loads a bubble (all write enables 0, ALU NOP).
  - On FMULT with MULT_LAT>1: go to MULTI, cnt=MULT_LAT-1.
  - On FAVERAGE with AV_LAT>1: go to MULTI, cnt=AV_LAT-1.
  - On FSTR_ONE with effective length L>1: go to BURST, cnt=L-1, `burst_idx`=0.
- MULTI: E register holds. `stall_out`=1. cnt decrements each non-stalled cycle. At cnt==1, the next edge returns to IDLE.
- BURST: each non-stalled cycle re-issues the store-plus-one and increments `burst_idx`. `stall_out`=1. cnt decrements. Leaves to IDLE after beat L-1.
- Effective L: `burst_len`=0 → 1; `burst_len`>BURST_MAX → BURST_MAX.
- `stall_in`=1: E register, cnt, `burst_idx` and state all freeze.
- `flush_in`=1: E register loads a bubble, state goes to IDLE, cnt and `burst_idx` go to 0. Flush has priority over `stall_in` and FSM progress.

## Timing
- D outputs are purely combinational from `funct`/`opcode`.
- E outputs take 1-cycle latency: valid at the edge after the decode cycle.
- MULT occupies E for exactly MULT_LAT cycles; `stall_out` is high for MULT_LAT-1 cycles starting the cycle after issue.
- A burst of L beats issues L consecutive E-stage stores; `stall_out` is high L-1 cycles.
- Reset (`rst_n`=0 at an edge) drives all registered outputs, `stall_out`, `burst_idx` and `illegal_o` to 0, and state to IDLE. Reset mid-burst or mid-MULT aborts immediately with no further beats.
- A new instruction is accepted in the same cycle the FSM returns to IDLE, when `stall_out`=0.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined: an undefined cmd with `valid_d` sets `illegal_o`. It stays high until reset, and the instruction still issues as a bubble.
- `CU_ILLEGAL_TRAP_EN` undefined: `illegal_o` is tied to 0, and undefined cmds are silently treated as FNOP.

## Test plan
- Reset, then FADD opcode 00 → next cycle ALUControlE=1, RegWriteE=1, MemWriteE=0, ALUSrcE=0, stall_out=0.
- FMULT, MULT_LAT=3 → ALUControlE=3 held 3 cycles; stall_out=1 for cycles 2–3; IDLE on cycle 4.
- FSTR_ONE, burst_len=4 → 4 beats, PlusOneE=MemWriteE=1, burst_idx 0,1,2,3; stall_out high for 3 cycles. Repeat with burst_len=0 → 1 beat and burst_len=31 → 16 beats.
- stall_in high 2 cycles mid-burst at burst_idx=1 → idx holds at 1 and total beats stay 4. flush_in at idx=2 together with stall_in → bubble next cycle, IDLE, idx=0.
- Undefined cmd 1111 → ALUControlE=0, RegWriteE=0; illegal_o=1 sticky with the macro, 0 without.
